// File: rtl/adc_pipe_stage_combiner_pkg.sv
// +----------------------------------------------------------------------+
// | adc_comb_pkg: width derivation and decode-mode constants shared by    |
// | the pipelined-ADC stage combiner. Rev 1.0                             |
// +----------------------------------------------------------------------+
`default_nettype none

package adc_comb_pkg;

  localparam int DECODE_TOP = 0;
  localparam int DECODE_POP = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Bits needed to hold thermometer levels 0..TH_W
  function automatic int stage_w(input int th_w);
    return clog2(th_w + 1);
  endfunction

  function automatic int shift_w(input int th_w, input int overlap);
    return stage_w(th_w) - overlap;
  endfunction

  function automatic int out_w(input int n_stages, input int th_w, input int overlap);
    return stage_w(th_w) + (n_stages - 1) * shift_w(th_w, overlap);
  endfunction

endpackage

`default_nettype wire

// File: rtl/adc_pipe_stage_combiner_decode.sv
// +----------------------------------------------------------------------+
// | adc_therm_decode: combinational thermometer lane decoder giving a     |
// | binary level and a bubble flag. Rev 1.0                               |
// +----------------------------------------------------------------------+
`default_nettype none

module adc_therm_decode
  import adc_comb_pkg::*;
#(
  parameter int TH_W        = 6,
  parameter int DECODE_MODE = DECODE_TOP,
  localparam int STAGE_W    = stage_w(TH_W)
) (
  input  logic [TH_W-1:0]    th,
  output logic [STAGE_W-1:0] value,
  output logic               err
);

  logic [STAGE_W-1:0] w_top;
  logic [STAGE_W-1:0] w_pop;
  logic               w_seen_one;

  // Scan from the top: any 0 found after the highest 1 is a bubble
  always_comb begin
    w_top      = '0;
    w_pop      = '0;
    err        = 1'b0;
    w_seen_one = 1'b0;
    for (int i = TH_W - 1; i >= 0; i--) begin
      if (th[i]) begin
        w_pop = w_pop + STAGE_W'(1);
        if (!w_seen_one) w_top = STAGE_W'(i + 1);
        w_seen_one = 1'b1;
      end else if (w_seen_one) begin
        err = 1'b1;
      end
    end
  end

  assign value = (DECODE_MODE == DECODE_POP) ? w_pop : w_top;

endmodule

`default_nettype wire

// File: rtl/adc_pipe_stage_combiner.sv
// +----------------------------------------------------------------------+
// | adc_pipe_stage_combiner: aligns N_STAGES thermometer stage results    |
// | and merges them by shifted addition with overlap. Rev 1.0             |
// +----------------------------------------------------------------------+
`default_nettype none

module adc_pipe_stage_combiner
  import adc_comb_pkg::*;
#(
  parameter int N_STAGES    = 5,
  parameter int TH_W        = 6,
  parameter int OVERLAP     = 1,
  parameter int DECODE_MODE = DECODE_TOP,
  localparam int STAGE_W    = stage_w(TH_W),
  localparam int SHIFT      = shift_w(TH_W, OVERLAP),
  localparam int OUT_W      = out_w(N_STAGES, TH_W, OVERLAP)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [N_STAGES*TH_W-1:0] th_in,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_code,
  output logic                     out_err,
  output logic                     out_ovf,
  output logic [15:0]              err_cnt
);

  localparam logic [2:0] c_PRIME_MAX = 3'(N_STAGES - 1);

  logic [STAGE_W-1:0]  w_lane_val [N_STAGES];
  logic [N_STAGES-1:0] w_lane_err;
  logic [OUT_W:0]      w_sum;
  logic                w_s_load;
  logic [2:0]          r_prime_cnt;
  logic                r_pend;

  // Element 0 of each chain is the D register; lane i is read N_STAGES-1-i beats later
  for (genvar gi = 0; gi < N_STAGES; gi++) begin : g_lane
    localparam int DEPTH = N_STAGES - 1 - gi;

    logic [STAGE_W-1:0] w_val;
    logic               w_err;
    logic [STAGE_W:0]   r_chain [DEPTH+1];

    adc_therm_decode #(
      .TH_W        (TH_W),
      .DECODE_MODE (DECODE_MODE)
    ) u_dec (
      .th    (th_in[gi*TH_W +: TH_W]),
      .value (w_val),
      .err   (w_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int m = 0; m <= DEPTH; m++) r_chain[m] <= '0;
      end else if (flush) begin
        for (int m = 0; m <= DEPTH; m++) r_chain[m] <= '0;
      end else if (in_valid) begin
        r_chain[0] <= {w_err, w_val};
        for (int m = 1; m <= DEPTH; m++) r_chain[m] <= r_chain[m-1];
      end
    end

    assign w_lane_val[gi] = r_chain[DEPTH][STAGE_W-1:0];
    assign w_lane_err[gi] = r_chain[DEPTH][STAGE_W];
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_STAGES; i++) begin
      w_sum = w_sum + ((OUT_W+1)'(w_lane_val[i]) << ((N_STAGES - 1 - i) * SHIFT));
    end
  end

  assign w_s_load = r_pend && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prime_cnt <= 3'd0;
      r_pend      <= 1'b0;
      out_valid   <= 1'b0;
      out_code    <= '0;
      out_err     <= 1'b0;
      out_ovf     <= 1'b0;
      err_cnt     <= 16'd0;
    end else begin
      if (flush) begin
        r_prime_cnt <= 3'd0;
        r_pend      <= 1'b0;
      end else if (in_valid) begin
        r_pend <= (r_prime_cnt == c_PRIME_MAX);
        if (r_prime_cnt != c_PRIME_MAX) r_prime_cnt <= r_prime_cnt + 3'd1;
      end else begin
        r_pend <= 1'b0;
      end

      out_valid <= w_s_load;
      if (w_s_load) begin
        out_code <= w_sum[OUT_W] ? '1 : w_sum[OUT_W-1:0];
        out_ovf  <= w_sum[OUT_W];
        out_err  <= |w_lane_err;
        if (|w_lane_err && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_adc_pipe_stage_combiner.sv
// +----------------------------------------------------------------------+
// | tb_adc_pipe_stage_combiner: directed self-checking bench for the      |
// | stage combiner across several parameter sets. Rev 1.0                 |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_adc_pipe_stage_combiner;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid;
  logic [29:0] th5;
  logic [13:0] th_c, th_d;
  logic [29:0] th_e;

  logic a_v, a_err, a_ovf, b_v, b_err, b_ovf;
  logic [10:0] a_code, b_code;
  logic [15:0] a_cnt, b_cnt;
  logic c_v, c_err, c_ovf, d_v, d_err, d_ovf, e_v, e_err, e_ovf;
  logic [5:0] c_code;
  logic [4:0] d_code, e_code;
  logic [15:0] c_cnt, d_cnt, e_cnt;

  int checks = 0;
  int errors = 0;
  int errbase;

  logic [5:0]  samp [8][5];
  logic [10:0] exp_a [8];
  logic [10:0] exp_b [8];
  logic        exp_e [8];

  always #5 clk = ~clk;

  adc_pipe_stage_combiner #(.N_STAGES(5), .TH_W(6), .OVERLAP(1), .DECODE_MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .th_in(th5),
    .out_valid(a_v), .out_code(a_code), .out_err(a_err), .out_ovf(a_ovf), .err_cnt(a_cnt));

  adc_pipe_stage_combiner #(.N_STAGES(5), .TH_W(6), .OVERLAP(1), .DECODE_MODE(1)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .th_in(th5),
    .out_valid(b_v), .out_code(b_code), .out_err(b_err), .out_ovf(b_ovf), .err_cnt(b_cnt));

  adc_pipe_stage_combiner #(.N_STAGES(2), .TH_W(7), .OVERLAP(0), .DECODE_MODE(0)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .th_in(th_c),
    .out_valid(c_v), .out_code(c_code), .out_err(c_err), .out_ovf(c_ovf), .err_cnt(c_cnt));

  adc_pipe_stage_combiner #(.N_STAGES(2), .TH_W(7), .OVERLAP(1), .DECODE_MODE(0)) u_d (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .th_in(th_d),
    .out_valid(d_v), .out_code(d_code), .out_err(d_err), .out_ovf(d_ovf), .err_cnt(d_cnt));

  adc_pipe_stage_combiner #(.N_STAGES(2), .TH_W(15), .OVERLAP(3), .DECODE_MODE(0)) u_e (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .th_in(th_e),
    .out_valid(e_v), .out_code(e_code), .out_err(e_err), .out_ovf(e_ovf), .err_cnt(e_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Beat k carries sample k-i on lane i
  function automatic logic [29:0] beat_word(input int k);
    logic [29:0] w;
    w = '0;
    for (int i = 0; i < 5; i++)
      if (k - i >= 0 && k - i < 8) w[i*6 +: 6] = samp[k-i][i];
    return w;
  endfunction

  task automatic check_beat(input int k);
    int s;
    if (k < 4) begin
      chk("prime_valid_a", a_v, 0);
      chk("prime_valid_b", b_v, 0);
    end else begin
      s = k - 4;
      chk("valid_a", a_v, 1);
      chk("valid_b", b_v, 1);
      chk("code_a", a_code, exp_a[s]);
      chk("code_b", b_code, exp_b[s]);
      chk("err_a", a_err, exp_e[s]);
      chk("err_b", b_err, exp_e[s]);
      chk("ovf_a", a_ovf, 0);
      chk("errcnt_a", a_cnt, errbase + ((s >= 5) ? 1 : 0));
    end
  endtask

  task automatic run_seq(input bit gapped);
    bit pend;
    int pidx, gap;
    pend = 0;
    pidx = 0;
    for (int k = 0; k < 12; k++) begin
      gap = gapped ? ((k % 3 == 0) ? 0 : (k % 3 == 1) ? 1 : 7) : 0;
      th5 = beat_word(k);
      in_valid = 1'b1;
      @(posedge clk); #1;
      if (pend) begin
        check_beat(pidx);
        pend = 0;
      end else if (gapped && k > 0) begin
        chk("early_valid", a_v, 0);
      end
      if (gap == 0) begin
        pend = 1;
        pidx = k;
      end else begin
        in_valid = 1'b0;
        th5 = '0;
        @(posedge clk); #1;
        check_beat(k);
        if (gap > 1) begin
          repeat (gap - 1) @(posedge clk);
          #1;
          chk("gap_valid", a_v, 0);
          if (k >= 4) chk("gap_hold", a_code, exp_a[k-4]);
        end
      end
    end
    in_valid = 1'b0;
    th5 = '0;
    if (pend) begin
      @(posedge clk); #1;
      check_beat(pidx);
    end
  endtask

  task automatic stream_beat(input bit expect_valid);
    th5 = {5{6'b000111}};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_valid", a_v, 32'(expect_valid));
    if (expect_valid) chk("stream_code", a_code, 1023);
  endtask

  task automatic flush_cycle(input bit with_beat);
    flush = 1'b1;
    in_valid = with_beat;
    th5 = {5{6'b000111}};
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    th5 = '0;
  endtask

  initial begin
    for (int s = 0; s < 8; s++)
      for (int i = 0; i < 5; i++) samp[s][i] = 6'b000111;
    for (int i = 0; i < 5; i++) begin
      samp[4][i] = 6'b000000;
      samp[5][i] = 6'b000000;
      samp[7][i] = 6'b000000;
    end
    samp[4][0] = 6'b111111;
    samp[5][2] = 6'b001011;
    samp[7][0] = 6'b000001;
    samp[7][4] = 6'b000011;
    exp_a = '{11'd1023, 11'd1023, 11'd1023, 11'd1023, 11'd1536, 11'd64, 11'd1023, 11'd258};
    exp_b = '{11'd1023, 11'd1023, 11'd1023, 11'd1023, 11'd1536, 11'd48, 11'd1023, 11'd258};
    exp_e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    th5 = '0;
    th_c = '0;
    th_d = '0;
    th_e = '0;
    #12;
    chk("rst_valid", a_v, 0);
    chk("rst_code", a_code, 0);
    chk("rst_err", a_err, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_cnt", a_cnt, 0);
    rst_n = 1'b1;

    // Gapless pass, then a flush that also swallows a beat, then the gapped pass
    errbase = 0;
    run_seq(1'b0);
    flush_cycle(1'b1);
    chk("flush_valid", a_v, 0);
    chk("flush_hold_a", a_code, 258);
    chk("flush_hold_b", b_code, 258);
    chk("flush_cnt", a_cnt, 1);
    errbase = 1;
    run_seq(1'b1);
    chk("cnt_mode1", b_cnt, 2);

    // Two-stage variants: overlap 0, overlap 1, and overflow saturation
    flush_cycle(1'b0);
    th_c = {7'h00, 7'h7F};
    th_d = {7'h00, 7'h01};
    th_e = {15'h0000, 15'h7FFF};
    in_valid = 1'b1;
    @(posedge clk); #1;
    th_c = {7'h7F, 7'h00};
    th_d = {7'h7F, 7'h00};
    th_e = {15'h7FFF, 15'h0000};
    @(posedge clk); #1;
    chk("c_prime_valid", c_v, 0);
    in_valid = 1'b0;
    th_c = '0;
    th_d = '0;
    th_e = '0;
    @(posedge clk); #1;
    chk("c_valid", c_v, 1);
    chk("c_code", c_code, 63);
    chk("c_ovf", c_ovf, 0);
    chk("d_code", d_code, 11);
    chk("d_ovf", d_ovf, 0);
    chk("e_code", e_code, 31);
    chk("e_ovf", e_ovf, 1);
    chk("e_err", e_err, 0);

    // Flush then asynchronous reset mid-stream, each followed by re-priming
    flush_cycle(1'b0);
    for (int i = 0; i < 4; i++) stream_beat(1'b0);
    stream_beat(1'b1);
    stream_beat(1'b1);
    chk("cnt_before_rst", a_cnt, 2);
    th5 = {5{6'b000111}};
    in_valid = 1'b1;
    rst_n = 1'b0;
    #2;
    chk("arst_valid", a_v, 0);
    chk("arst_code", a_code, 0);
    chk("arst_err", a_err, 0);
    chk("arst_ovf", a_ovf, 0);
    chk("arst_cnt", a_cnt, 0);
    chk("arst_code_c", c_code, 0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) stream_beat(1'b0);
    stream_beat(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
